increment_counter: RTL and testbench



---
 rtl/increment_counter_pkg.sv | 8 +
 rtl/increment_counter_count_incrementer.sv | 25 ++
 rtl/increment_counter.sv | 34 +++
 tb/tb_increment_counter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/increment_counter_pkg.sv
// Shared definitions for the load-and-increment counter and the blocks that consume its output.
package increment_counter_pkg;

    localparam int COUNTER_WIDTH_DEFAULT = 4;

    typedef logic [COUNTER_WIDTH_DEFAULT-1:0] count_t;

endpackage

// File: rtl/increment_counter_count_incrementer.sv
// Combinational WIDTH-bit +1 unit; the carry out of the top bit is dropped so the sum wraps.
module count_incrementer
    import increment_counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] sum
);

    // carry[i] is the carry into bit i; carry[0] is the constant +1.
    logic [WIDTH-1:0] carry;

    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign sum[gi] = a[gi] ^ carry[gi];
            if (gi < WIDTH - 1) begin : g_carry
                assign carry[gi+1] = a[gi] & carry[gi];
            end
        end
    endgenerate

endmodule

// File: rtl/increment_counter.sv
// Registered counter: every rising edge stores num + 1 (mod 2^WIDTH); reset clears out asynchronously.
module increment_counter
    import increment_counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] num,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    count_incrementer #(
        .WIDTH(WIDTH)
    ) u_incrementer (
        .a  (num),
        .sum(count_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Output comes straight from the register, so num never reaches out combinationally.
    assign out = count_reg;

endmodule

// File: tb/tb_increment_counter.sv
// Randomized self-checking bench for increment_counter at WIDTH 4 and WIDTH 8.
`timescale 1ns/1ps
module tb_increment_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] num4;
    logic [3:0] out4;
    logic [7:0] num8;
    logic [7:0] out8;

    int checks   = 0;
    int failures = 0;
    int m4;
    int m8;

    always #5 clk = ~clk;

    increment_counter #(.WIDTH(4)) dut4 (
        .clk  (clk),
        .reset(reset),
        .num  (num4),
        .out  (out4)
    );

    increment_counter #(.WIDTH(8)) dut8 (
        .clk  (clk),
        .reset(reset),
        .num  (num8),
        .out  (out8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One transaction: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic tick(input logic rst_v, input logic [3:0] n4, input logic [7:0] n8);
        logic was_reset;
        @(negedge clk);
        was_reset = reset;
        reset = rst_v;
        num4  = n4;
        num8  = n8;
        if (rst_v && !was_reset) begin
            #1;
            check("async_rst4", 32'(out4), 32'd0);
            check("async_rst8", 32'(out8), 32'd0);
        end
        @(posedge clk);
        #1;
        if (rst_v) begin
            m4 = 0;
            m8 = 0;
        end else begin
            m4 = (int'(n4) + 1) % 16;
            m8 = (int'(n8) + 1) % 256;
        end
        check("load4", 32'(out4), 32'(m4));
        check("load8", 32'(out8), 32'(m8));
        $display("txn rst=%0b num4=%h out4=%h num8=%h out8=%h", rst_v, n4, out4, n8, out8);
    endtask

    initial begin
        int expct;
        reset = 1'b1;
        num4  = 4'($urandom);
        num8  = 8'($urandom);

        // Reset before any clock edge has occurred.
        #1;
        check("rst_idle4", 32'(out4), 32'd0);
        check("rst_idle8", 32'(out8), 32'd0);

        // Edges while reset is held must not load anything.
        for (int i = 0; i < 3; i++) tick(1'b1, 4'($urandom), 8'($urandom));

        // Directed loads and wrap boundaries.
        tick(1'b0, 4'h5, 8'hFF);
        tick(1'b0, 4'hA, 8'h7F);
        tick(1'b0, 4'hF, 8'h00);
        tick(1'b0, 4'h0, 8'hFE);

        // Reset coinciding with a rising edge wins.
        @(negedge clk);
        num4 = 4'h5;
        num8 = 8'h33;
        @(posedge clk);
        reset = 1'b1;
        #1;
        check("rst_edge4", 32'(out4), 32'd0);
        check("rst_edge8", 32'(out8), 32'd0);

        // Closed loop: num follows out, count must climb 1..F then wrap to 0.
        expct = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            reset = 1'b0;
            num4  = out4;
            num8  = out8;
            @(posedge clk);
            #1;
            expct = (expct + 1) % 16;
            check("loop4", 32'(out4), 32'(expct));
            $display("txn loop step=%0d out4=%h", i, out4);
        end

        // Run up to 15 in closed loop, then reset mid-cycle.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            num4 = out4;
            @(posedge clk);
        end
        #1;
        check("loop_at_f", 32'(out4), 32'hF);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst4", 32'(out4), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        num4  = out4;
        @(posedge clk);
        #1;
        check("post_rst4", 32'(out4), 32'd1);
        $display("txn mid-count reset release out4=%h", out4);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 200; i++) begin
            tick(($urandom % 16) == 0, 4'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
